// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared state encoding and default widths for the RAM access controller
package ram_ctrl_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_FILL  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// rtl/ram_access_ctrl_if.sv - request/response, fill and RAM-side signal bundle
interface ram_access_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              fill_start;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;
    logic              fill_done;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    // system side: processor requests plus the RAM array's read port
    modport master (
        output req_valid, req_we, req_addr, req_wdata, fill_start, fill_value, ram_dout,
        input  req_ready, rsp_valid, rsp_rdata, fill_busy, fill_done, ram_addr, ram_din, ram_we
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, fill_start, fill_value, ram_dout,
        output req_ready, rsp_valid, rsp_rdata, fill_busy, fill_done, ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/ram_fill_seq.sv
// rtl/ram_fill_seq.sv - block-fill address counter; one extra bit so the sweep ends on carry
module ram_fill_seq #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_active,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last,
    output logic              o_done
);
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] r_cnt;
    logic            r_done;

    // r_cnt holds the next address to write; address 0 is issued by the start itself
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= i_active & r_cnt[ADDR_W];
            if (i_start) begin
                r_cnt <= CNT_ONE;
            end else if (i_active && !r_cnt[ADDR_W]) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign o_addr = r_cnt[ADDR_W-1:0];
    assign o_last = r_cnt[ADDR_W];
    assign o_done = r_done;

endmodule

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - request sequencer in front of the RAM array with block-fill mode
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input logic          i_clk,
    input logic          i_rst_n,
    ram_access_ctrl_if.slave bus
);
    localparam logic [1:0] LAT_END = 2'(RD_LAT);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
    logic [DATA_W-1:0] r_ram_din, w_ram_din_nxt;
    logic              r_ram_we, w_ram_we_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_fill_busy, w_fill_busy_nxt;
    logic [1:0]        r_lat_cnt, w_lat_cnt_nxt;

    logic              w_req_ready;
    logic              w_fill_go;
    logic              w_fill_active;
    logic [ADDR_W-1:0] w_fill_addr;
    logic              w_fill_last;
    logic              w_fill_done;

    assign w_req_ready   = (r_state == ST_IDLE) & ~bus.fill_start & i_rst_n;
    assign w_fill_go     = (r_state == ST_IDLE) & bus.fill_start;
    assign w_fill_active = (r_state == ST_FILL);

    ram_fill_seq #(
        .ADDR_W (ADDR_W)
    ) u_fill_seq (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (w_fill_go),
        .i_active (w_fill_active),
        .o_addr   (w_fill_addr),
        .o_last   (w_fill_last),
        .o_done   (w_fill_done)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_ram_we    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_fill_busy <= 1'b0;
            r_lat_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_din   <= w_ram_din_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_fill_busy <= w_fill_busy_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_din_nxt   = r_ram_din;
        w_ram_we_nxt    = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_fill_busy_nxt = r_fill_busy;
        w_lat_cnt_nxt   = r_lat_cnt;

        case (r_state)
            ST_IDLE: begin
                // fill has priority; w_req_ready is already low when fill_start is high
                if (bus.fill_start) begin
                    w_ram_addr_nxt  = '0;
                    w_ram_din_nxt   = bus.fill_value;
                    w_ram_we_nxt    = 1'b1;
                    w_fill_busy_nxt = 1'b1;
                    w_state_nxt     = ST_FILL;
                end else if (bus.req_valid && w_req_ready) begin
                    w_ram_addr_nxt = bus.req_addr;
                    if (bus.req_we) begin
                        w_ram_din_nxt = bus.req_wdata;
                        w_ram_we_nxt  = 1'b1;
                        w_state_nxt   = ST_WRITE;
                    end else begin
                        w_lat_cnt_nxt = '0;
                        w_state_nxt   = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_READ: begin
                if (r_lat_cnt == LAT_END) begin
                    w_rsp_rdata_nxt = bus.ram_dout;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + 2'd1;
                end
            end
            ST_FILL: begin
                if (w_fill_last) begin
                    w_fill_busy_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_ram_addr_nxt = w_fill_addr;
                    w_ram_we_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.fill_busy = r_fill_busy;
    assign bus.fill_done = w_fill_done;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_din   = r_ram_din;
    assign bus.ram_we    = r_ram_we;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - self-checking bench for ram_access_ctrl with a behavioural RAM
module tb_ram_access_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   rsp_cnt;
    int   done_cnt;
    int   busy_cnt;

    logic [7:0] ram_mem [256];
    logic [7:0] model   [256];

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    ram_access_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    ram_access_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous-read RAM array: data appears one edge after the address
    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= ram_mem[bus.ram_addr];
    end

    always @(negedge clk) begin
        if (bus.rsp_valid) rsp_cnt++;
        if (bus.fill_done) done_cnt++;
        if (bus.fill_busy) busy_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // called #1 after a rising edge; returns at the same phase with the controller idle
    task automatic do_req(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                          output logic [7:0] rdata);
        int n;
        rdata = '0;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            chk("req_accept_timeout", 32'(n), 32'd0);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (we) begin
            chk("wr_we", 32'(bus.ram_we), 32'd1);
            chk("wr_addr", 32'(bus.ram_addr), 32'(addr));
            chk("wr_din", 32'(bus.ram_din), 32'(wdata));
            @(posedge clk); #1;
            chk("wr_we_one_cycle", 32'(bus.ram_we), 32'd0);
            chk("wr_no_rsp", 32'(bus.rsp_valid), 32'd0);
            model[addr] = wdata;
        end else begin
            chk("rd_addr", 32'(bus.ram_addr), 32'(addr));
            chk("rd_no_we", 32'(bus.ram_we), 32'd0);
            @(posedge clk); #1;
            chk("rd_not_early", 32'(bus.rsp_valid), 32'd0);
            @(posedge clk); #1;
            chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rd_ready_with_rsp", 32'(bus.req_ready), 32'd1);
            rdata = bus.rsp_rdata;
            @(posedge clk); #1;
            chk("rd_rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    // starts a fill and runs to the FILL_DONE sample; leaves req_* untouched
    task automatic run_fill(input logic [7:0] val);
        int iters;
        int bad;
        int b0;
        int r0;
        bus.fill_value = val;
        bus.fill_start = 1'b1;
        #1;
        chk("fill_blocks_ready", 32'(bus.req_ready), 32'd0);
        b0 = busy_cnt;
        r0 = rsp_cnt;
        @(posedge clk); #1;
        bus.fill_start = 1'b0;
        chk("fill_busy_set", 32'(bus.fill_busy), 32'd1);
        chk("fill_first_we", 32'(bus.ram_we), 32'd1);
        chk("fill_first_addr", 32'(bus.ram_addr), 32'd0);
        chk("fill_din", 32'(bus.ram_din), 32'(val));
        iters = 0;
        bad   = 0;
        while (!bus.fill_done && iters < 300) begin
            @(posedge clk); #1;
            iters++;
            if (!bus.fill_done && (bus.ram_addr != 8'(iters) || !bus.ram_we || bus.req_ready))
                bad++;
        end
        chk("fill_cycles", 32'(iters), 32'd256);
        chk("fill_sequence", 32'(bad), 32'd0);
        chk("fill_busy_len", 32'(busy_cnt - b0), 32'd256);
        chk("fill_end_busy", 32'(bus.fill_busy), 32'd0);
        chk("fill_end_we", 32'(bus.ram_we), 32'd0);
        chk("fill_no_wrap", 32'(bus.ram_addr), 32'hFF);
        chk("fill_end_ready", 32'(bus.req_ready), 32'd1);
        chk("fill_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        for (int i = 0; i < 256; i++) model[i] = val;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[9];
        logic [7:0] rd;
        logic [7:0] got_q[$];
        int         d0;
        int         n;
        int         nacc;

        n_chk = 0; n_err = 0;
        rsp_cnt = 0; done_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'h00;
            model[i]   = 8'h00;
        end
        bus.ram_dout = 8'h00;

        tbl[0] = '{1'b1, 8'h05, 8'hAF, 8'h00};
        tbl[1] = '{1'b0, 8'h05, 8'h00, 8'hAF};
        tbl[2] = '{1'b1, 8'h00, 8'h01, 8'h00};
        tbl[3] = '{1'b1, 8'hFF, 8'hFE, 8'h00};
        tbl[4] = '{1'b0, 8'h00, 8'h00, 8'h01};
        tbl[5] = '{1'b0, 8'hFF, 8'h00, 8'hFE};
        tbl[6] = '{1'b1, 8'h00, 8'h77, 8'h00};
        tbl[7] = '{1'b0, 8'h00, 8'h00, 8'h77};
        tbl[8] = '{1'b0, 8'h42, 8'h00, 8'h00};

        // reset held with a request pending
        rst_n = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 8'h33; bus.req_wdata = 8'h99;
        bus.fill_start = 1'b0; bus.fill_value = 8'h00;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_ready_c%0d", c), 32'(bus.req_ready), 32'd0);
            chk($sformatf("rst_we_c%0d", c), 32'(bus.ram_we), 32'd0);
            chk($sformatf("rst_rsp_c%0d", c), 32'(bus.rsp_valid), 32'd0);
        end
        chk("rst_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_din", 32'(bus.ram_din), 32'd0);
        chk("rst_busy", 32'(bus.fill_busy), 32'd0);
        chk("rst_done", 32'(bus.fill_done), 32'd0);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_access", 32'(ram_mem[8'h33]), 32'd0);

        // directed table: write/read pairs including address extremes
        for (int i = 0; i < 9; i++) begin
            do_req(tbl[i].we, tbl[i].addr, tbl[i].data, rd);
            if (!tbl[i].we) chk($sformatf("tbl_rd_%0d", i), 32'(rd), 32'(tbl[i].exp));
        end

        // full-memory fill then spot reads
        d0 = done_cnt;
        run_fill(8'h3C);
        @(posedge clk); #1;
        chk("fill_done_pulse", 32'(bus.fill_done), 32'd0);
        chk("fill_done_once", 32'(done_cnt - d0), 32'd1);
        chk("fill_addr_hold", 32'(bus.ram_addr), 32'hFF);
        do_req(1'b0, 8'h00, 8'h00, rd); chk("fill_rd_00", 32'(rd), 32'h3C);
        do_req(1'b0, 8'h80, 8'h00, rd); chk("fill_rd_80", 32'(rd), 32'h3C);
        do_req(1'b0, 8'hFF, 8'h00, rd); chk("fill_rd_ff", 32'(rd), 32'h3C);

        // fill and write presented together: fill wins, write waits for FILL_DONE
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 8'h10; bus.req_wdata = 8'h11;
        run_fill(8'h55);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("cont_we", 32'(bus.ram_we), 32'd1);
        chk("cont_addr", 32'(bus.ram_addr), 32'h10);
        chk("cont_din", 32'(bus.ram_din), 32'h11);
        model[8'h10] = 8'h11;
        @(posedge clk); #1;
        do_req(1'b0, 8'h10, 8'h00, rd); chk("cont_rd_10", 32'(rd), 32'h11);
        do_req(1'b0, 8'h20, 8'h00, rd); chk("cont_rd_20", 32'(rd), 32'h55);

        // back-to-back reads with REQ_VALID held
        for (int a = 1; a <= 4; a++) do_req(1'b1, 8'(a), 8'(8'hA0 + a), rd);
        bus.req_we = 1'b0; bus.req_addr = 8'h01; bus.req_valid = 1'b1;
        nacc = 0;
        for (int k = 0; k <= 12; k++) begin
            bit acc;
            #1;
            if (k < 12) chk($sformatf("b2b_ready_k%0d", k), 32'(bus.req_ready), 32'((k % 3) == 0));
            if (bus.rsp_valid) got_q.push_back(bus.rsp_rdata);
            acc = bus.req_ready && bus.req_valid;
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                if (nacc < 4) bus.req_addr = 8'(nacc + 1);
                else bus.req_valid = 1'b0;
            end
        end
        chk("b2b_rsp_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < got_q.size() && i < 4; i++)
            chk($sformatf("b2b_data_%0d", i), 32'(got_q[i]), 32'(model[i + 1]));

        // reset in the middle of a fill
        bus.fill_value = 8'h77; bus.fill_start = 1'b1;
        @(posedge clk); #1;
        bus.fill_start = 1'b0;
        n = 0;
        while (bus.ram_addr != 8'h40 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("midfill_reach_40", 32'(bus.ram_addr), 32'h40);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midfill_we_drop", 32'(bus.ram_we), 32'd0);
        chk("midfill_busy_drop", 32'(bus.fill_busy), 32'd0);
        chk("midfill_ready_rst", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("midfill_idle_ready", 32'(bus.req_ready), 32'd1);
        repeat (300) @(posedge clk);
        #1;
        chk("midfill_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midfill_busy_low", 32'(bus.fill_busy), 32'd0);
        for (int i = 0; i <= 8'h40; i++) model[i] = 8'h77;
        do_req(1'b0, 8'h40, 8'h00, rd); chk("midfill_rd_40", 32'(rd), 32'(model[8'h40]));
        do_req(1'b0, 8'h41, 8'h00, rd); chk("midfill_rd_41", 32'(rd), 32'(model[8'h41]));

        // randomized traffic against the transaction-level memory model
        for (int i = 0; i < 150; i++) begin
            bit         we;
            logic [7:0] a;
            logic [7:0] d;
            we = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 255));
            d  = 8'($urandom);
            if (we) do_req(1'b1, a, d, rd);
            else begin
                do_req(1'b0, a, 8'h00, rd);
                chk($sformatf("rand_rd_%0h", a), 32'(rd), 32'(model[a]));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
